// File: rtl/sram_loop_sequencer.sv
// Records sample words into SRAMControl on a sample strobe and plays them back once or looped.
// Owns every SRAM control line and absorbs the SRAM's one-edge registered read latency.
module sram_loop_sequencer #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8192
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              tick,
  input  logic              record,
  input  logic              play,
  input  logic              stop,
  input  logic              loop,
  input  logic [DATA_W-1:0] sampleIn,
  output logic [DATA_W-1:0] sampleOut,
  output logic              sampleValid,
  output logic              done,
  output logic              busy,
  output logic              overrun,
  output logic [ADDR_W:0]   length,
  output logic [ADDR_W-1:0] sramAddress,
  output logic [DATA_W-1:0] sramDataIn,
  output logic              sramWriteEnable,
  output logic              sramRequestCE,
  input  logic [DATA_W-1:0] sramDataOut
);

  typedef enum logic [2:0] {
    IDLE,
    REC_WAIT,
    REC_WR,
    PLAY_WAIT,
    PLAY_RD,
    PLAY_CAP
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_P = DEPTH[ADDR_W:0];

  state_t          state;
  logic [ADDR_W:0] ptr;
  logic            loop_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state           <= IDLE;
      ptr             <= '0;
      loop_q          <= 1'b0;
      sampleOut       <= '0;
      sampleValid     <= 1'b0;
      done            <= 1'b0;
      busy            <= 1'b0;
      overrun         <= 1'b0;
      length          <= '0;
      sramAddress     <= '0;
      sramDataIn      <= '0;
      sramWriteEnable <= 1'b0;
      sramRequestCE   <= 1'b0;
    end else begin
      sampleValid <= 1'b0;
      done        <= 1'b0;

      if (stop) begin
        // A write issued on the previous edge was already sampled by the SRAM and counted.
        if (state != IDLE) begin
          state <= IDLE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        sramWriteEnable <= 1'b0;
        sramRequestCE   <= 1'b0;
      end else if (record) begin
        state           <= REC_WAIT;
        busy            <= 1'b1;
        ptr             <= '0;
        length          <= '0;
        overrun         <= 1'b0;
        sramWriteEnable <= 1'b0;
        sramRequestCE   <= 1'b0;
      end else if (play && (length != '0)) begin
        state           <= PLAY_WAIT;
        busy            <= 1'b1;
        ptr             <= '0;
        overrun         <= 1'b0;
        loop_q          <= loop;
        sramWriteEnable <= 1'b0;
        sramRequestCE   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
          end

          REC_WAIT: begin
            if (tick) begin
              sramAddress     <= ptr[ADDR_W-1:0];
              sramDataIn      <= sampleIn;
              sramWriteEnable <= 1'b1;
              sramRequestCE   <= 1'b1;
              ptr             <= ptr + 1'b1;
              length          <= ptr + 1'b1;
              state           <= REC_WR;
            end
          end

          REC_WR: begin
            sramWriteEnable <= 1'b0;
            sramRequestCE   <= 1'b0;
            if (tick) overrun <= 1'b1;
            if (ptr == DEPTH_P) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= REC_WAIT;
            end
          end

          PLAY_WAIT: begin
            if (tick) begin
              sramAddress     <= ptr[ADDR_W-1:0];
              sramWriteEnable <= 1'b0;
              sramRequestCE   <= 1'b1;
              state           <= PLAY_RD;
            end
          end

          PLAY_RD: begin
            if (tick) overrun <= 1'b1;
            state <= PLAY_CAP;
          end

          PLAY_CAP: begin
            if (tick) overrun <= 1'b1;
            sampleOut     <= sramDataOut;
            sampleValid   <= 1'b1;
            sramRequestCE <= 1'b0;
            if ((ptr + 1'b1) == length) begin
              if (loop_q) begin
                ptr   <= '0;
                state <= PLAY_WAIT;
              end else begin
                ptr   <= ptr + 1'b1;
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              ptr   <= ptr + 1'b1;
              state <= PLAY_WAIT;
            end
          end

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sram_loop_sequencer.sv
// Directed bench for sram_loop_sequencer with a small registered-read SRAM model.
module tb_sram_loop_sequencer;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 32;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              tick = 1'b0;
  logic              record = 1'b0;
  logic              play = 1'b0;
  logic              stop = 1'b0;
  logic              loop = 1'b0;
  logic [DATA_W-1:0] sampleIn = '0;
  logic [DATA_W-1:0] sampleOut;
  logic              sampleValid;
  logic              done;
  logic              busy;
  logic              overrun;
  logic [ADDR_W:0]   length;
  logic [ADDR_W-1:0] sramAddress;
  logic [DATA_W-1:0] sramDataIn;
  logic              sramWriteEnable;
  logic              sramRequestCE;
  logic [DATA_W-1:0] sramDataOut = '0;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] mem [0:15];
  logic [DATA_W-1:0] vals [0:2];

  always #5 CLK = ~CLK;

  // Behavioural SRAMControl: samples address/control on the edge, read data valid after it.
  always @(posedge CLK) begin
    if (sramRequestCE) begin
      if (sramWriteEnable) mem[sramAddress[3:0]] <= sramDataIn;
      else sramDataOut <= mem[sramAddress[3:0]];
    end
  end

  sram_loop_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .tick(tick), .record(record), .play(play), .stop(stop),
    .loop(loop), .sampleIn(sampleIn), .sampleOut(sampleOut), .sampleValid(sampleValid),
    .done(done), .busy(busy), .overrun(overrun), .length(length),
    .sramAddress(sramAddress), .sramDataIn(sramDataIn), .sramWriteEnable(sramWriteEnable),
    .sramRequestCE(sramRequestCE), .sramDataOut(sramDataOut)
  );

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) @(negedge CLK);
  endtask

  task automatic pulse_cmd(input logic r, input logic p, input logic s);
    @(negedge CLK);
    record = r; play = p; stop = s;
    @(negedge CLK);
    record = 1'b0; play = 1'b0; stop = 1'b0;
  endtask

  task automatic do_tick(input logic [DATA_W-1:0] d);
    @(negedge CLK);
    tick = 1'b1; sampleIn = d;
    @(negedge CLK);
    tick = 1'b0;
  endtask

  task automatic test_reset;
    cyc(2);
    checks++;
    if ({sampleOut, sampleValid, done, busy, overrun, length, sramAddress, sramDataIn,
         sramWriteEnable, sramRequestCE} !== '0) begin
      errors++; $display("FAIL reset_outputs got nonzero outputs (busy=%0b len=%0d we=%0b ce=%0b)",
                         busy, length, sramWriteEnable, sramRequestCE);
    end
    RST = 1'b0;
    pulse_cmd(1'b0, 1'b1, 1'b0);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL play_empty_busy got=%0b exp=0", busy); end
    pulse_cmd(1'b1, 1'b0, 1'b0);
    do_tick(32'h5555_0001);
    checks++;
    if (sramWriteEnable !== 1'b1 || length !== 14'd1) begin
      errors++; $display("FAIL midrec_we got we=%0b len=%0d exp we=1 len=1", sramWriteEnable, length);
    end
    #1 RST = 1'b1;
    #1;
    checks++;
    if (sramWriteEnable !== 1'b0 || sramRequestCE !== 1'b0 || busy !== 1'b0 || length !== '0) begin
      errors++; $display("FAIL async_reset got we=%0b ce=%0b busy=%0b len=%0d exp all 0",
                         sramWriteEnable, sramRequestCE, busy, length);
    end
    cyc(1);
    RST = 1'b0;
    cyc(1);
  endtask

  task automatic test_record;
    pulse_cmd(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      do_tick(vals[i]);
      checks++;
      if (sramWriteEnable !== 1'b1 || sramRequestCE !== 1'b1 || sramAddress !== 13'(i) ||
          sramDataIn !== vals[i]) begin
        errors++; $display("FAIL rec_write[%0d] got we=%0b ce=%0b addr=%0d data=%h exp 1 1 %0d %h",
                           i, sramWriteEnable, sramRequestCE, sramAddress, sramDataIn, i, vals[i]);
      end
      cyc(1);
      checks++;
      if (sramWriteEnable !== 1'b0 || sramRequestCE !== 1'b0) begin
        errors++; $display("FAIL rec_pulse_end[%0d] got we=%0b ce=%0b exp 0 0",
                           i, sramWriteEnable, sramRequestCE);
      end
      cyc(8);
    end
    checks++;
    if (length !== 14'd3) begin errors++; $display("FAIL rec_length got=%0d exp=3", length); end
    pulse_cmd(1'b0, 1'b0, 1'b1);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL rec_stop_done got done=%0b busy=%0b exp 1 0", done, busy);
    end
    cyc(1);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL rec_done_width got=%0b exp=0", done); end
  endtask

  task automatic test_play(input logic lp, input int n);
    loop = lp;
    pulse_cmd(1'b0, 1'b1, 1'b0);
    loop = 1'b0;
    for (int i = 0; i < n; i++) begin
      do_tick('0);
      checks++;
      if (sramRequestCE !== 1'b1 || sramWriteEnable !== 1'b0 || sramAddress !== 13'(i % 3)) begin
        errors++; $display("FAIL play_issue[%0d] got ce=%0b we=%0b addr=%0d exp 1 0 %0d",
                           i, sramRequestCE, sramWriteEnable, sramAddress, i % 3);
      end
      cyc(1);
      checks++;
      if (sampleValid !== 1'b0) begin
        errors++; $display("FAIL play_early_valid[%0d] got=%0b exp=0", i, sampleValid);
      end
      cyc(1);
      checks++;
      if (sampleValid !== 1'b1 || sampleOut !== vals[i % 3] || sramRequestCE !== 1'b0) begin
        errors++; $display("FAIL play_data[%0d] got valid=%0b data=%h ce=%0b exp 1 %h 0",
                           i, sampleValid, sampleOut, sramRequestCE, vals[i % 3]);
      end
      checks++;
      if (done !== ((!lp && i == 2) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL play_done[%0d] got=%0b", i, done);
      end
      cyc(1);
      checks++;
      if (sampleValid !== 1'b0) begin
        errors++; $display("FAIL play_valid_width[%0d] got=%0b exp=0", i, sampleValid);
      end
      cyc(6);
    end
    checks++;
    if (busy !== lp) begin errors++; $display("FAIL play_end_busy got=%0b exp=%0b", busy, lp); end
    if (lp) begin
      pulse_cmd(1'b0, 1'b0, 1'b1);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        errors++; $display("FAIL loop_stop got done=%0b busy=%0b exp 1 0", done, busy);
      end
    end
  endtask

  task automatic test_depth_limit;
    pulse_cmd(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      do_tick(32'hD0 + 32'(i));
      checks++;
      if (sramWriteEnable !== 1'b1 || sramAddress !== 13'(i) || sramDataIn !== 32'hD0 + 32'(i)) begin
        errors++; $display("FAIL depth_write[%0d] got we=%0b addr=%0d data=%h", i,
                           sramWriteEnable, sramAddress, sramDataIn);
      end
      cyc(1);
      checks++;
      if (done !== (i == 3) || busy !== (i != 3)) begin
        errors++; $display("FAIL depth_state[%0d] got done=%0b busy=%0b", i, done, busy);
      end
      cyc(8);
    end
    checks++;
    if (length !== 14'd4) begin errors++; $display("FAIL depth_length got=%0d exp=4", length); end
    do_tick(32'hD4);
    checks++;
    if (sramWriteEnable !== 1'b0 || sramRequestCE !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL depth_extra_tick got we=%0b ce=%0b ovr=%0b busy=%0b exp all 0",
                         sramWriteEnable, sramRequestCE, overrun, busy);
    end
    cyc(3);
  endtask

  task automatic test_back_to_back;
    pulse_cmd(1'b0, 1'b1, 1'b0);
    do_tick('0);
    cyc(1);
    tick = 1'b1;
    @(negedge CLK);
    tick = 1'b0;
    checks++;
    if (overrun !== 1'b1 || sampleValid !== 1'b1 || sampleOut !== 32'hD0) begin
      errors++; $display("FAIL overrun got ovr=%0b valid=%0b data=%h exp 1 1 d0",
                         overrun, sampleValid, sampleOut);
    end
    pulse_cmd(1'b0, 1'b1, 1'b1);
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || sramRequestCE !== 1'b0 || overrun !== 1'b1) begin
      errors++; $display("FAIL stop_play got busy=%0b done=%0b ce=%0b ovr=%0b exp 0 1 0 1",
                         busy, done, sramRequestCE, overrun);
    end
    do_tick('0);
    cyc(2);
    checks++;
    if (sramRequestCE !== 1'b0 || sampleValid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL stop_play_idle got ce=%0b valid=%0b busy=%0b exp 0 0 0",
                         sramRequestCE, sampleValid, busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vals[0] = 32'hA1; vals[1] = 32'hB2; vals[2] = 32'hC3;
    test_reset;
    test_record;
    test_play(1'b0, 3);
    test_play(1'b1, 4);
    test_depth_limit;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
